ss_engine: RTL

Save-state sequencer that drives the mapper save-state port from the host side. On a save command it walks every slot address, samples the mapper's read-back byte and streams it out. On a load command it accepts a byte stream and writes each byte back into the mapper with synthesized strobe edges. It sits between the menu/host DMA and every mapper core; the system bus mux routes `ss_dat` onto the CPU data path and `ss_m2` onto `m2` while `ss_act` is high.

---
 rtl/ss_engine_if.sv | 32 +++
 rtl/ss_engine.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ss_engine_if.sv
// Host/mapper side signal bundle of the save-state sequencer.
// The slave modport is the engine; the master modport is the host/mapper side.
interface ss_engine_if;
  logic       cmd_save;
  logic       cmd_load;
  logic       cmd_abort;
  logic       busy;
  logic       done;
  logic [7:0] sv_dat;
  logic       sv_vld;
  logic       sv_rdy;
  logic [7:0] ld_dat;
  logic       ld_vld;
  logic       ld_rdy;
  logic       ss_act;
  logic [7:0] ss_addr;
  logic       ss_we;
  logic [7:0] ss_dat;
  logic       ss_m2;
  logic [7:0] ss_rdat;
  logic [7:0] ss_crc;

  modport slave (
    input  cmd_save, cmd_load, cmd_abort, sv_rdy, ld_dat, ld_vld, ss_rdat,
    output busy, done, sv_dat, sv_vld, ld_rdy, ss_act, ss_addr, ss_we, ss_dat, ss_m2, ss_crc
  );

  modport master (
    output cmd_save, cmd_load, cmd_abort, sv_rdy, ld_dat, ld_vld, ss_rdat,
    input  busy, done, sv_dat, sv_vld, ld_rdy, ss_act, ss_addr, ss_we, ss_dat, ss_m2, ss_crc
  );
endinterface

// File: rtl/ss_engine.sv
// Save-state sequencer: streams mapper slots out on save, writes them back with synthesized m2 on load.
// Optional SS_CRC_EN macro enables a running CRC-8 (poly 0x07) over transferred bytes.
module ss_engine #(
  parameter int SS_LEN = 128,
  parameter int SETTLE = 2,
  parameter int STB_W  = 2
) (
  input logic        clk,
  input logic        rst_n,
  ss_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, S_SET, S_OUT, L_WAIT, L_SET, L_STB, L_HOLD, FIN} state_t;

  localparam logic [7:0] LAST     = 8'(SS_LEN - 1);
  localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] STB_LAST = 8'(STB_W - 1);

  state_t     state;
  logic [7:0] cnt, wcnt;
  logic [7:0] sv_dat, ss_addr, ss_dat;
  logic       busy, done, sv_vld, ld_rdy, ss_act, ss_we, ss_m2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wcnt    <= '0;
      sv_dat  <= '0;
      ss_addr <= '0;
      ss_dat  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sv_vld  <= 1'b0;
      ld_rdy  <= 1'b0;
      ss_act  <= 1'b0;
      ss_we   <= 1'b0;
      ss_m2   <= 1'b0;
    end else if (bus.cmd_abort && state != IDLE) begin
      // Dropping m2 here may commit a half-written slot; that is accepted.
      state   <= IDLE;
      sv_dat  <= '0;
      ss_addr <= '0;
      ss_dat  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sv_vld  <= 1'b0;
      ld_rdy  <= 1'b0;
      ss_act  <= 1'b0;
      ss_we   <= 1'b0;
      ss_m2   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_save || bus.cmd_load) begin
          busy    <= 1'b1;
          ss_act  <= 1'b1;
          cnt     <= '0;
          wcnt    <= '0;
          ss_addr <= '0;
          if (bus.cmd_save) state <= S_SET;
          else begin
            state  <= L_WAIT;
            ld_rdy <= 1'b1;
          end
        end
        S_SET: if (wcnt == SET_LAST) begin
          sv_dat <= bus.ss_rdat;
          sv_vld <= 1'b1;
          state  <= S_OUT;
        end else wcnt <= wcnt + 8'd1;
        S_OUT: if (bus.sv_rdy) begin
          sv_vld <= 1'b0;
          if (cnt == LAST) begin
            state  <= FIN;
            done   <= 1'b1;
            busy   <= 1'b0;
            ss_act <= 1'b0;
          end else begin
            cnt     <= cnt + 8'd1;
            ss_addr <= cnt + 8'd1;
            wcnt    <= '0;
            state   <= S_SET;
          end
        end
        L_WAIT: if (bus.ld_vld) begin
          ld_rdy <= 1'b0;
          ss_dat <= bus.ld_dat;
          ss_we  <= 1'b1;
          state  <= L_SET;
        end
        L_SET: begin
          ss_m2 <= 1'b1;
          wcnt  <= '0;
          state <= L_STB;
        end
        L_STB: if (wcnt == STB_LAST) begin
          ss_m2 <= 1'b0;
          state <= L_HOLD;
        end else wcnt <= wcnt + 8'd1;
        L_HOLD: begin
          ss_we <= 1'b0;
          if (cnt == LAST) begin
            state  <= FIN;
            done   <= 1'b1;
            busy   <= 1'b0;
            ss_act <= 1'b0;
          end else begin
            cnt     <= cnt + 8'd1;
            ss_addr <= cnt + 8'd1;
            ld_rdy  <= 1'b1;
            state   <= L_WAIT;
          end
        end
        FIN: begin
          // Return the mapper-side buses to their idle value only once m2 is long gone.
          ss_addr <= '0;
          ss_dat  <= '0;
          sv_dat  <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.sv_dat  = sv_dat;
  assign bus.sv_vld  = sv_vld;
  assign bus.ld_rdy  = ld_rdy;
  assign bus.ss_act  = ss_act;
  assign bus.ss_addr = ss_addr;
  assign bus.ss_we   = ss_we;
  assign bus.ss_dat  = ss_dat;
  assign bus.ss_m2   = ss_m2;

`ifdef SS_CRC_EN
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  logic [7:0] crc;
  logic       crc_clr, crc_upd;
  logic [7:0] crc_byte;

  // Byte handshakes the FSM actually takes; an abort in the same cycle discards the byte.
  assign crc_clr  = (state == IDLE) && (bus.cmd_save || bus.cmd_load);
  assign crc_upd  = !bus.cmd_abort &&
                    (((state == S_OUT) && sv_vld && bus.sv_rdy) ||
                     ((state == L_WAIT) && ld_rdy && bus.ld_vld));
  assign crc_byte = (state == S_OUT) ? sv_dat : bus.ld_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       crc <= '0;
    else if (crc_clr) crc <= '0;
    else if (crc_upd) crc <= crc8(crc, crc_byte);
  end

  assign bus.ss_crc = crc;
`else
  assign bus.ss_crc = 8'h00;
`endif
endmodule
